mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_burst_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants, state encodings and line-align helper for the memory port arbiter
package mem_arb_pkg;

    // Arbiter FSM state encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t I_XFER = 2'd1;
    localparam arb_state_t D_XFER = 2'd2;

    localparam int WORD_BYTES       = 4;
    localparam int LINE_WORDS_DEF   = 4;
    localparam int OFFSET_W         = $clog2(LINE_WORDS_DEF) + 2;

    // Byte-offset width of a line holding line_words 32-bit words
    function automatic int offset_width(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    // Clear the in-line byte offset so the address points at word 0 of its line
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int off_w);
        logic [63:0] mask;
        mask = (64'd1 << off_w) - 64'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/mem_burst_counter.sv
// rtl/mem_burst_counter.sv - beat counter for one line burst with clear, enable and last-beat flag
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return count to word 0 (burst grant)
//   en         : advance one word (accepted memory beat)
//   count      : current word index within the line
//   last       : count is on the final word of the line
module mem_burst_counter #(
    parameter int LINE_WORDS = 4,
    localparam int CNT_W     = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            // LINE_WORDS is a power of two, so the final beat wraps back to 0
            count <= count + 1'b1;
        end
    end

    assign last = (count == CNT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the main-memory port between ICache refills and DCache refills/writebacks
//
// Optional build macro: MEM_ARB_RR_EN (round-robin on simultaneous requests;
// otherwise the DCache always wins a tie).
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   IReq, IAddr                 : ICache refill request and miss address
//   IRData, IRValid, IDone      : refill word to ICache, its valid, burst-complete pulse
//   DReq, DWe, DAddr            : DCache request, writeback(1)/refill(0), line address
//   DWData, DWReady             : writeback word and its consumed strobe
//   DRData, DRValid, DDone      : refill word to DCache, its valid, burst-complete pulse
//   MemReq, MemWe, MemAddr,
//   MemWData                    : memory beat request, direction, word address, write data
//   MemRData, MemAck            : memory read data and beat handshake
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRData,
    output logic              IRValid,
    output logic              IDone,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic              DWReady,
    output logic [DATA_W-1:0] DRData,
    output logic              DRValid,
    output logic              DDone,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemAck
);

    localparam int CNT_W      = $clog2(LINE_WORDS);
    localparam int LINE_OFF_W = offset_width(LINE_WORDS);

    arb_state_t        state;
    logic [ADDR_W-1:0] base;
    logic              wflag;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;

    logic busy;
    logic i_pend;
    logic d_pend;
    logic grant_i;
    logic grant_d;
    logic grant;
    logic beat_ack;
    logic last_ack;

    assign busy = (state != IDLE);

    // A requester still sees its own Done in the cycle after its burst, and
    // its Req is allowed to still be high then; that must not re-grant it.
    assign i_pend = IReq & ~IDone;
    assign d_pend = DReq & ~DDone;

`ifdef MEM_ARB_RR_EN
    // 1 = DCache was served last; reset value favours the ICache as "last"
    logic last_d;

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            if (d_pend && i_pend) begin
                grant_d = ~last_d;
                grant_i = last_d;
            end else begin
                grant_d = d_pend;
                grant_i = i_pend;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (grant_d) begin
            last_d <= 1'b1;
        end else if (grant_i) begin
            last_d <= 1'b0;
        end
    end
`else
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            grant_d = d_pend;
            grant_i = i_pend & ~d_pend;
        end
    end
`endif

    assign grant    = grant_i | grant_d;
    assign beat_ack = MemAck & busy;
    assign last_ack = beat_ack & cnt_last;

    mem_burst_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (grant),
        .en    (beat_ack),
        .count (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            base  <= '0;
            wflag <= 1'b0;
            IDone <= 1'b0;
            DDone <= 1'b0;
        end else begin
            IDone <= 1'b0;
            DDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state <= D_XFER;
                        base  <= ADDR_W'(line_align(64'(DAddr), LINE_OFF_W));
                        wflag <= DWe;
                    end else if (grant_i) begin
                        state <= I_XFER;
                        base  <= ADDR_W'(line_align(64'(IAddr), LINE_OFF_W));
                        wflag <= 1'b0;
                    end
                end
                I_XFER: begin
                    if (last_ack) begin
                        state <= IDLE;
                        IDone <= 1'b1;
                    end
                end
                D_XFER: begin
                    if (last_ack) begin
                        state <= IDLE;
                        DDone <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory side: everything is qualified by busy so IDLE presents all zeros
    assign MemReq   = busy;
    assign MemWe    = busy & wflag;
    assign MemAddr  = busy ? (base + (ADDR_W'(cnt) << $clog2(WORD_BYTES))) : '0;
    assign MemWData = (busy && wflag) ? DWData : '0;

    // Cache side: read data is a straight pass-through qualified by the ack
    assign IRData  = MemRData;
    assign DRData  = MemRData;
    assign IRValid = beat_ack & (state == I_XFER);
    assign DRValid = beat_ack & (state == D_XFER) & ~wflag;
    assign DWReady = beat_ack & (state == D_XFER) & wflag;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRData;
    logic        IRValid;
    logic        IDone;
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic        DWReady;
    logic [31:0] DRData;
    logic        DRValid;
    logic        DDone;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;

    int checks   = 0;
    int failures = 0;
    int dw_idx   = 0;
    logic [31:0] rd_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .LINE_WORDS (LW)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .IReq     (IReq),
        .IAddr    (IAddr),
        .IRData   (IRData),
        .IRValid  (IRValid),
        .IDone    (IDone),
        .DReq     (DReq),
        .DWe      (DWe),
        .DAddr    (DAddr),
        .DWData   (DWData),
        .DWReady  (DWReady),
        .DRData   (DRData),
        .DRValid  (DRValid),
        .DDone    (DDone),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemRData (MemRData),
        .MemAck   (MemAck)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory + cache model for one burst. Starts in any cycle before MemReq,
    // returns positioned in the Done cycle with the served request dropped.
    task automatic serve_burst(input logic is_d, input logic we, input logic [31:0] base,
                               input int stall_beat, input int stall_cyc, output int gap);
        int n;
        logic [31:0] rd;
        logic [31:0] exp;
        n = 0;
        while (MemReq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        gap = n;
        checks++;
        if (MemReq !== 1'b1) begin
            failures++;
            $display("FAIL burst_start MemReq=%b required 1", MemReq);
            return;
        end
        for (int k = 0; k < LW; k++) begin
            if (k == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    MemAck = 1'b0;
                    #1;
                    checks++;
                    if (MemAddr !== base + 32'(k * 4) || MemReq !== 1'b1 || IRValid !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_hold beat=%0d MemAddr=%h MemReq=%b IRValid=%b required %h 1 0",
                                 k, MemAddr, MemReq, IRValid, base + 32'(k * 4));
                    end
                    tick();
                end
            end
            checks++;
            if (MemAddr !== base + 32'(k * 4) || MemWe !== we) begin
                failures++;
                $display("FAIL beat_addr beat=%0d MemAddr=%h MemWe=%b required %h %b",
                         k, MemAddr, MemWe, base + 32'(k * 4), we);
            end
            MemAck = 1'b1;
            if (!we) begin
                rd = $urandom;
                MemRData = rd;
                rd_q.push_back(rd);
            end
            #1;
            if (!we) begin
                checks++;
                if ((is_d ? DRValid : IRValid) !== 1'b1 || (is_d ? IRValid : DRValid) !== 1'b0
                    || DWReady !== 1'b0) begin
                    failures++;
                    $display("FAIL read_valid beat=%0d IRValid=%b DRValid=%b DWReady=%b is_d=%b",
                             k, IRValid, DRValid, DWReady, is_d);
                end else begin
                    exp = rd_q.pop_front();
                    checks++;
                    if ((is_d ? DRData : IRData) !== exp) begin
                        failures++;
                        $display("FAIL read_data beat=%0d got=%h required %h",
                                 k, (is_d ? DRData : IRData), exp);
                    end
                end
            end else begin
                checks++;
                if (DWReady !== 1'b1 || DRValid !== 1'b0 || MemWData !== 32'hA0 + 32'(k)) begin
                    failures++;
                    $display("FAIL write_beat beat=%0d DWReady=%b DRValid=%b MemWData=%h required 1 0 %h",
                             k, DWReady, DRValid, MemWData, 32'hA0 + 32'(k));
                end
                if (DWReady === 1'b1) dw_idx++;
            end
            tick();
            MemAck = 1'b0;
            DWData = 32'hA0 + 32'(dw_idx);
        end
        checks++;
        if (IDone !== ~is_d || DDone !== is_d || MemReq !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse IDone=%b DDone=%b MemReq=%b required %b %b 0",
                     IDone, DDone, MemReq, ~is_d, is_d);
        end
        if (is_d) DReq = 1'b0;
        else IReq = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        IReq = 0; IAddr = 0; DReq = 0; DWe = 0; DAddr = 0;
        DWData = 32'hDEAD_BEEF; MemRData = 0; MemAck = 0;
        #2;
        checks++;
        if ({MemReq, MemWe, IDone, DDone, IRValid, DRValid, DWReady} !== 7'b0
            || MemAddr !== 32'h0 || MemWData !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs ctl=%b MemAddr=%h MemWData=%h required 0",
                     {MemReq, MemWe, IDone, DDone, IRValid, DRValid, DWReady}, MemAddr, MemWData);
        end
        tick();
        tick();
        rst_n = 1'b1;
        DWData = 32'h0;
        // MemAck while idle must neither start nor advance anything
        for (int c = 0; c < 4; c++) begin
            MemAck = (c < 2);
            MemRData = 32'h1234_5678;
            #1;
            checks++;
            if ({MemReq, MemWe, IDone, DDone, IRValid, DRValid, DWReady} !== 7'b0 || MemAddr !== 32'h0) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d ctl=%b MemAddr=%h required 0",
                         c, {MemReq, MemWe, IDone, DDone, IRValid, DRValid, DWReady}, MemAddr);
            end
            tick();
        end
        MemAck = 1'b0;
    endtask

    task automatic test_i_refill();
        int gap;
        IReq = 1'b1;
        IAddr = 32'h0000_1004;
        serve_burst(1'b0, 1'b0, 32'h0000_1000, -1, 0, gap);
        checks++;
        if (gap !== 1) begin
            failures++;
            $display("FAIL i_grant_latency got=%0d required 1", gap);
        end
        tick();
        checks++;
        if (IDone !== 1'b0 || MemReq !== 1'b0) begin
            failures++;
            $display("FAIL i_after_done IDone=%b MemReq=%b required 0 0", IDone, MemReq);
        end
    endtask

    task automatic test_d_writeback();
        int gap;
        dw_idx = 0;
        DWData = 32'hA0;
        DReq = 1'b1;
        DWe = 1'b1;
        DAddr = 32'h0000_2000;
        serve_burst(1'b1, 1'b1, 32'h0000_2000, -1, 0, gap);
        DWe = 1'b0;
        checks++;
        if (dw_idx !== LW) begin
            failures++;
            $display("FAIL d_words_consumed got=%0d required %0d", dw_idx, LW);
        end
        tick();
    endtask

    task automatic test_tie();
        int gap;
        logic first_d;
`ifdef MEM_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        IReq = 1'b1;
        IAddr = 32'h0000_601C;
        DReq = 1'b1;
        DWe = 1'b0;
        DAddr = 32'h0000_4008;
        serve_burst(first_d, 1'b0, first_d ? 32'h0000_4000 : 32'h0000_6010, -1, 0, gap);
        serve_burst(~first_d, 1'b0, first_d ? 32'h0000_6010 : 32'h0000_4000, -1, 0, gap);
        checks++;
        if (gap !== 1) begin
            failures++;
            $display("FAIL back_to_back_gap got=%0d required 1", gap);
        end
        tick();
    endtask

    task automatic test_stall();
        int gap;
        IReq = 1'b1;
        IAddr = 32'h0000_3000;
        serve_burst(1'b0, 1'b0, 32'h0000_3000, 1, 5, gap);
        tick();
    endtask

    task automatic test_abort();
        int gap;
        IReq = 1'b1;
        IAddr = 32'h0000_5008;
        tick();
        MemAck = 1'b1;
        MemRData = 32'h5555_0000;
        tick();
        tick();
        MemAck = 1'b0;
        checks++;
        if (MemAddr !== 32'h0000_5008 || MemReq !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre MemAddr=%h MemReq=%b required 00005008 1", MemAddr, MemReq);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (MemReq !== 1'b0 || MemAddr !== 32'h0 || IDone !== 1'b0) begin
            failures++;
            $display("FAIL abort_async MemReq=%b MemAddr=%h IDone=%b required 0 0 0",
                     MemReq, MemAddr, IDone);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (IDone !== 1'b0 || MemReq !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_done IDone=%b MemReq=%b required 0 0", IDone, MemReq);
            end
        end
        rst_n = 1'b1;
        serve_burst(1'b0, 1'b0, 32'h0000_5000, -1, 0, gap);
        checks++;
        if (gap !== 1) begin
            failures++;
            $display("FAIL abort_restart_latency got=%0d required 1", gap);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_i_refill();
        test_d_writeback();
        test_tie();
        test_stall();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
